// File: rtl/montador_linha.sv
// montador_linha: assembles a stream of words into cache lines for the hashing
// core. One assembly slot plus one output slot, so a new line can be built
// while the core stalls the previous one with trava.
module montador_linha #(
    parameter int TAM_PALAVRA        = 64,
    parameter int PALAVRAS_POR_LINHA = 8,
    parameter int TAM_ENDERECO       = 64
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [TAM_PALAVRA-1:0]                     palavra_in,
    input  logic [TAM_ENDERECO-1:0]                    endereco_in,
    input  logic                                       palavra_valida,
    output logic                                       palavra_pronta,
    input  logic                                       trava,
    output logic [TAM_PALAVRA*PALAVRAS_POR_LINHA-1:0]  linha_cache,
    output logic [TAM_ENDERECO-1:0]                    endereco,
    output logic                                       linha_valida,
    output logic                                       erro_alinhamento,
    output logic [31:0]                                linhas_enviadas
);

    localparam int TAM_LINHA  = TAM_PALAVRA * PALAVRAS_POR_LINHA;
    localparam int TAM_CNT    = $clog2(PALAVRAS_POR_LINHA);
    localparam int BITS_ALINH = $clog2(TAM_LINHA / 8);
    localparam logic [TAM_CNT-1:0] ULTIMA = TAM_CNT'(PALAVRAS_POR_LINHA - 1);

    typedef enum logic {MONTANDO, CHEIA} estado_t;

    estado_t                 estado, prox_estado;
    logic [TAM_CNT-1:0]      cnt, prox_cnt;
    logic [TAM_LINHA-1:0]    buf_linha, linha_montada;
    logic [TAM_ENDERECO-1:0] buf_end, end_montado;
    logic                    transf, retirada;
    logic                    carrega_nova, carrega_pend;

    assign palavra_pronta = (estado == MONTANDO);
    assign transf         = palavra_valida && palavra_pronta;
    assign retirada       = linha_valida && !trava;

    // Assembly buffer with the current word merged in; feeds both the buffer
    // and the direct path to the output slot when the last word arrives.
    always_comb begin
        linha_montada = buf_linha;
        linha_montada[cnt*TAM_PALAVRA +: TAM_PALAVRA] = palavra_in;
        end_montado = (cnt == '0) ? endereco_in : buf_end;
    end

    // Next-state logic: count words, decide whether a finished line goes
    // straight out or waits in CHEIA for the output slot to be taken.
    always_comb begin
        prox_estado  = estado;
        prox_cnt     = cnt;
        carrega_nova = 1'b0;
        carrega_pend = 1'b0;
        case (estado)
            MONTANDO: begin
                if (transf) begin
                    if (cnt == ULTIMA) begin
                        prox_cnt = '0;
                        if (!linha_valida || retirada)
                            carrega_nova = 1'b1;
                        else
                            prox_estado = CHEIA;
                    end else begin
                        prox_cnt = cnt + 1'b1;
                    end
                end
            end
            CHEIA: begin
                if (retirada) begin
                    carrega_pend = 1'b1;
                    prox_estado  = MONTANDO;
                end
            end
            default: prox_estado = MONTANDO;
        endcase
    end

    // State and word-counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= MONTANDO;
            cnt    <= '0;
        end else begin
            estado <= prox_estado;
            cnt    <= prox_cnt;
        end
    end

    // Assembly slot: store every accepted word; latch the base address on word 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_linha <= '0;
            buf_end   <= '0;
        end else if (transf) begin
            buf_linha <= linha_montada;
            buf_end   <= end_montado;
        end
    end

    // Output slot: loaded only with a new line, so it is stable while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            linha_cache  <= '0;
            endereco     <= '0;
            linha_valida <= 1'b0;
        end else if (carrega_nova) begin
            linha_cache  <= linha_montada;
            endereco     <= end_montado;
            linha_valida <= 1'b1;
        end else if (carrega_pend) begin
            linha_cache  <= buf_linha;
            endereco     <= buf_end;
            linha_valida <= 1'b1;
        end else if (retirada) begin
            linha_valida <= 1'b0;
        end
    end

    // Count of lines taken by the core; wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            linhas_enviadas <= '0;
        else if (retirada)
            linhas_enviadas <= linhas_enviadas + 32'd1;
    end

    // Sticky misalignment flag, checked on the word-0 address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            erro_alinhamento <= 1'b0;
        else if (transf && cnt == '0 && endereco_in[BITS_ALINH-1:0] != '0)
            erro_alinhamento <= 1'b1;
    end

endmodule

// File: tb/tb_montador_linha.sv
// Bench for montador_linha: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the two-slot line assembler.
module tb_montador_linha;

    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  palavra_in;
    logic [63:0]  endereco_in;
    logic         palavra_valida;
    logic         palavra_pronta;
    logic         trava;
    logic [511:0] linha_cache;
    logic [63:0]  endereco;
    logic         linha_valida;
    logic         erro_alinhamento;
    logic [31:0]  linhas_enviadas;

    montador_linha #(
        .TAM_PALAVRA(64),
        .PALAVRAS_POR_LINHA(8),
        .TAM_ENDERECO(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .palavra_in(palavra_in),
        .endereco_in(endereco_in),
        .palavra_valida(palavra_valida),
        .palavra_pronta(palavra_pronta),
        .trava(trava),
        .linha_cache(linha_cache),
        .endereco(endereco),
        .linha_valida(linha_valida),
        .erro_alinhamento(erro_alinhamento),
        .linhas_enviadas(linhas_enviadas)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model state
    logic [63:0]  q_pal[$];
    logic [63:0]  m_end_asm;
    logic [511:0] m_out, m_pend;
    logic [63:0]  m_out_end, m_pend_end;
    bit           m_outv, m_cheia, m_err;
    logic [31:0]  m_cnt;

    task automatic verifica(input string tag, input logic [511:0] obs, input logic [511:0] esp);
        total++;
        if (obs !== esp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    task automatic model_reset();
        q_pal.delete();
        m_end_asm  = '0;
        m_out      = '0;
        m_pend     = '0;
        m_out_end  = '0;
        m_pend_end = '0;
        m_outv     = 1'b0;
        m_cheia    = 1'b0;
        m_err      = 1'b0;
        m_cnt      = '0;
    endtask

    task automatic confere();
        verifica("pronta", 512'(palavra_pronta), 512'(!m_cheia));
        verifica("valida", 512'(linha_valida), 512'(m_outv));
        verifica("linha", linha_cache, m_out);
        verifica("endereco", 512'(endereco), 512'(m_out_end));
        verifica("erro", 512'(erro_alinhamento), 512'(m_err));
        verifica("enviadas", 512'(linhas_enviadas), 512'(m_cnt));
    endtask

    // One clock cycle: drive inputs, advance the model, compare after the edge.
    task automatic ciclo(input bit v, input logic [63:0] w, input logic [63:0] a, input bit t);
        bit pronta, xfer, take;
        logic [511:0] l;
        palavra_valida = v;
        palavra_in     = w;
        endereco_in    = a;
        trava          = t;
        pronta = !m_cheia;
        xfer   = v && pronta;
        take   = m_outv && !t;
        @(posedge clk);
        #1;
        if (take) m_cnt = m_cnt + 32'd1;
        if (xfer) begin
            if (q_pal.size() == 0) begin
                m_end_asm = a;
                if (a[5:0] != 6'd0) m_err = 1'b1;
            end
            q_pal.push_back(w);
        end
        if (xfer && q_pal.size() == 8) begin
            l = '0;
            for (int k = 0; k < 8; k++) l[64*k +: 64] = q_pal[k];
            q_pal.delete();
            if (!m_outv || take) begin
                m_out = l; m_out_end = m_end_asm; m_outv = 1'b1;
            end else begin
                m_pend = l; m_pend_end = m_end_asm; m_cheia = 1'b1;
            end
        end else if (m_cheia && take) begin
            m_out = m_pend; m_out_end = m_pend_end; m_cheia = 1'b0;
        end else if (take) begin
            m_outv = 1'b0;
        end
        confere();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without a clock.
    task automatic aplica_reset();
        palavra_valida = 1'b0;
        trava          = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        confere();
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic envia_linha(input logic [63:0] base_w, input logic [63:0] a, input bit t);
        for (int i = 0; i < 8; i++) ciclo(1'b1, base_w + 64'(i), a, t);
    endtask

    initial begin
        rst = 1'b1; palavra_valida = 1'b0; palavra_in = '0; endereco_in = '0; trava = 1'b0;
        model_reset();
        #3;
        confere();
        @(posedge clk);
        #3;
        rst = 1'b0;

        // 1: basic line, address 0x1000
        envia_linha(64'h0, 64'h1000, 1'b0);
        verifica("t1_valida", 512'(linha_valida), 512'(1));
        verifica("t1_end", 512'(endereco), 512'(64'h1000));
        verifica("t1_lo", 512'(linha_cache[63:0]), 512'(0));
        verifica("t1_hi", 512'(linha_cache[511:448]), 512'(7));
        ciclo(1'b0, '0, '0, 1'b0);
        verifica("t1_cnt", 512'(linhas_enviadas), 512'(1));
        verifica("t1_vfim", 512'(linha_valida), 512'(0));

        // 2: stall with two lines in flight
        aplica_reset();
        envia_linha(64'h100, 64'h2000, 1'b1);
        envia_linha(64'h200, 64'h2040, 1'b1);
        verifica("t2_pronta", 512'(palavra_pronta), 512'(0));
        for (int i = 0; i < 4; i++) ciclo(1'b1, 64'hDEAD, 64'h0, 1'b1);
        verifica("t2_hold", 512'(linha_cache[63:0]), 512'(64'h100));
        ciclo(1'b0, '0, '0, 1'b0);
        verifica("t2_l2", 512'(linha_cache[63:0]), 512'(64'h200));
        verifica("t2_pr", 512'(palavra_pronta), 512'(1));
        verifica("t2_cnt", 512'(linhas_enviadas), 512'(1));
        ciclo(1'b0, '0, '0, 1'b0);

        // 3: three lines back to back
        aplica_reset();
        for (int i = 0; i < 3; i++) envia_linha(64'(i * 16), 64'(i * 64), 1'b0);
        ciclo(1'b0, '0, '0, 1'b0);
        verifica("t3_cnt", 512'(linhas_enviadas), 512'(3));

        // 4: misaligned word-0 address, flag is sticky
        aplica_reset();
        envia_linha(64'h40, 64'h1004, 1'b0);
        verifica("t4_end", 512'(endereco), 512'(64'h1004));
        envia_linha(64'h50, 64'h1040, 1'b0);
        ciclo(1'b0, '0, '0, 1'b0);
        verifica("t4_erro", 512'(erro_alinhamento), 512'(1));

        // 5: reset mid-line and mid-CHEIA
        for (int i = 0; i < 5; i++) ciclo(1'b1, 64'hAA00 + 64'(i), 64'h3000, 1'b0);
        aplica_reset();
        envia_linha(64'hB00, 64'h4000, 1'b1);
        envia_linha(64'hC00, 64'h4040, 1'b1);
        aplica_reset();
        verifica("t5_valida", 512'(linha_valida), 512'(0));
        envia_linha(64'hE00, 64'h5000, 1'b1);
        verifica("t5_lo", 512'(linha_cache[63:0]), 512'(64'hE00));

        // 6: counter wrap
        force dut.linhas_enviadas = 32'hFFFF_FFFF;
        #1;
        release dut.linhas_enviadas;
        m_cnt = 32'hFFFF_FFFF;
        ciclo(1'b0, '0, '0, 1'b1);
        ciclo(1'b0, '0, '0, 1'b0);
        verifica("t6_wrap", 512'(linhas_enviadas), 512'(0));

        // Random traffic
        aplica_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [63:0] a;
            if ($urandom_range(0, 599) == 0) aplica_reset();
            a = {$urandom, $urandom};
            if ($urandom_range(0, 15) != 0) a[5:0] = 6'd0;
            ciclo($urandom_range(0, 3) != 0, {$urandom, $urandom}, a, $urandom_range(0, 2) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
